// File: rtl/bit_permute_pipe_if.sv
// Stream interface for bit_permute_pipe.
// Carries both stream sides plus the status outputs.
//   in_valid/in_ready/in_data/in_mode     producer -> engine word stream
//   out_valid/out_ready/out_data/out_mode engine -> consumer word stream
//   fifo_level                            output FIFO occupancy, 0..DEPTH
//   word_count                            completed output handshakes, wraps
// The engine uses modport slave. The surrounding harness uses modport master.
interface bit_permute_pipe_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [1:0]       in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       out_mode;
    logic [LW-1:0]    fifo_level;
    logic [15:0]      word_count;

    modport master (
        output in_valid, in_data, in_mode, out_ready,
        input  in_ready, out_valid, out_data, out_mode, fifo_level, word_count
    );

    modport slave (
        input  in_valid, in_data, in_mode, out_ready,
        output in_ready, out_valid, out_data, out_mode, fifo_level, word_count
    );
endinterface

// File: rtl/bit_permute_pipe.sv
// Streaming bit-permutation engine.
// A word and its mode are captured into stage S1. The permutation is
// combinational from S1, and the result is written into a DEPTH-entry
// circular output FIFO.
// Modes:
//   0 = pass
//   1 = full bit reverse
//   2 = byte reverse
//   3 = nibble swap within each byte
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    stream and status signals (bit_permute_pipe_if.slave)
module bit_permute_pipe #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    bit_permute_pipe_if.slave    bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int NB = WIDTH / 8;
    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

    logic             s1_valid;
    logic [WIDTH-1:0] s1_data;
    logic [1:0]       s1_mode;
    logic [WIDTH-1:0] perm;

    logic [WIDTH-1:0] mem_data [DEPTH];
    logic [1:0]       mem_mode [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    level;
    logic [15:0]      count;

    logic not_full;
    logic accept;
    logic push;
    logic pop;

    // Only registered state feeds not_full.
    // A same-cycle pop therefore never frees a slot for this cycle's push.
    assign not_full = (level < FULL_LEVEL);
    assign accept   = bus.in_valid & bus.in_ready;
    assign push     = s1_valid & not_full;
    assign pop      = (level != '0) & bus.out_ready;

    assign bus.in_ready   = rst_n & (~s1_valid | not_full);
    assign bus.out_valid  = (level != '0);
    assign bus.out_data   = mem_data[rd_ptr];
    assign bus.out_mode   = mem_mode[rd_ptr];
    assign bus.fifo_level = level;
    assign bus.word_count = count;

    always_comb begin
        perm = s1_data;
        case (s1_mode)
            2'd1: begin
                for (int i = 0; i < WIDTH; i++) begin
                    perm[i] = s1_data[WIDTH-1-i];
                end
            end
            2'd2: begin
                for (int j = 0; j < NB; j++) begin
                    perm[8*j +: 8] = s1_data[8*(NB-1-j) +: 8];
                end
            end
            2'd3: begin
                for (int j = 0; j < NB; j++) begin
                    perm[8*j +: 8] = {s1_data[8*j +: 4], s1_data[8*j+4 +: 4]};
                end
            end
            default: perm = s1_data;
        endcase
    end

    // S1 fills on accept.
    // S1 empties when its word moves into the FIFO without a refill.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_mode  <= '0;
        end else begin
            if (accept) begin
                s1_valid <= 1'b1;
                s1_data  <= bus.in_data;
                s1_mode  <= bus.in_mode;
            end else if (push) begin
                s1_valid <= 1'b0;
            end
        end
    end

    // The storage is cleared on reset so that out_data and out_mode read 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                mem_data[k] <= '0;
                mem_mode[k] <= '0;
            end
        end else if (push) begin
            mem_data[wr_ptr] <= perm;
            mem_mode[wr_ptr] <= s1_mode;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                count  <= count + 16'd1;
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end
endmodule

// File: doc/bit_permute_pipe.md
# bit_permute_pipe

Streaming bit-permutation engine: accepts WIDTH-bit words with a per-word mode over a valid/ready handshake and applies one of four reorderings: pass, full bit reverse, byte reverse or nibble swap. Results are buffered in a DEPTH-entry output FIFO. This is the registered, flow-controlled, multi-mode generalisation of the team's 8-bit combinational bit-reverse function. It sits between a producer and consumer stream in the datapath test harnesses.

## Interface
- WIDTH, default 16: data width in bits; must be a multiple of 8 and at least 8.
- DEPTH, default 4: output FIFO entries; power of 2 and at least 2.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset. One clock domain; reset polarity and asynchronous behaviour are fixed.
- in_valid  in  1  producer has a word.
- in_ready  out  1  block can accept a word.
- in_data  in  WIDTH  input word.
- in_mode  in  2  permutation applied to this word.
- out_valid  out  1  FIFO head is valid.
- out_ready  in  1  consumer takes the head.
- out_data  out  WIDTH  permuted word.
- out_mode  out  2  mode that produced out_data.
- fifo_level  out  $clog2(DEPTH)+1  FIFO occupancy, from 0 to DEPTH.
- word_count  out  16  count of completed output handshakes; wraps.

## Operation
- Input handshake: a word is accepted on a rising edge where in_valid=1 and in_ready=1. in_data and in_mode are captured into stage register S1, and s1_valid is set.
- Mode encoding, with i the bit index and j the byte index:
  - 0 = pass: out=in.
  - 1 = bit reverse: out[i]=in[WIDTH-1-i].
  - 2 = byte reverse: byte j goes to byte WIDTH/8-1-j, bit order inside each byte is preserved. For WIDTH=8 this equals pass.
  - 3 = nibble swap: within every byte, out[7:4]=in[3:0] and out[3:0]=in[7:4].
- Mode travels with the word. Mode changes between consecutive words take effect with no bubble.
- S1 to FIFO transfer: the permutation is combinational from S1. The result and mode are written into the FIFO on any edge where s1_valid=1 and fifo_level<DEPTH.
- in_ready = rst_n & (!s1_valid | fifo_level<DEPTH).
  - It uses registered state only; there is no combinational path from out_ready to in_ready.
  - A pop in the same cycle does not free a slot for that cycle's S1 transfer.
- FIFO:
  - Circular buffer with read and write pointers that wrap modulo DEPTH.
  - out_valid = (fifo_level != 0).
  - out_data and out_mode come directly from the head entry.
  - A pop occurs on an edge where out_valid=1 and out_ready=1.
  - There is no bypass: an empty FIFO never forwards S1 in the same cycle.
- Simultaneous push and pop: the level is unchanged and both pointers advance.
  - At level DEPTH, a push is blocked and the pop proceeds, so the level becomes DEPTH-1.
  - At level 0, no pop occurs.
- word_count increments by 1 on each output handshake and wraps from 0xFFFF to 0x0000.
- Total capacity is DEPTH+1 words (FIFO plus S1).
- Reset, including assertion mid-stream:
  - All in-flight words are discarded, and FIFO contents are don't-care.
  - s1_valid=0, pointers=0.
  - out_valid=0, fifo_level=0, word_count=0, in_ready=0 while rst_n=0.
  - out_data and out_mode are 0.
  - in_ready goes to 1 as soon as rst_n deasserts.

## Timing
- Latency into an empty block: a word accepted at edge k is written to the FIFO at edge k+1. out_valid=1 with that word is visible after edge k+1, and it can be popped at edge k+2 at the earliest.
- Throughput: 1 word per clock sustained while out_ready=1 continuously.
- Backpressure: with out_ready=0, in_ready falls after DEPTH+1 accepted words. It rises in the cycle after the first pop frees a FIFO slot and S1 drains (registered recovery).
- Ordering: strict FIFO order is required. No word is lost or duplicated under any interleaving of in_valid and out_ready.
- in_data and in_mode are sampled only on accepting edges; values at other times are ignored.

## Test plan
All scenarios use WIDTH=16, DEPTH=4.
1. Reset, then single words with out_ready=1:
   - 0xBEEF/mode0 -> 0xBEEF.
   - 0x00F1/mode1 -> 0x8F00.
   - 0x12AB/mode2 -> 0xAB12.
   - 0x12AB/mode3 -> 0x21BA.
   - Each appears 1 edge after acceptance with out_mode matching.
2. Back-to-back stream of 16 random words with rotating modes and out_ready=1 -> one output per clock, in order, matching a reference model. word_count=16.
3. Hold out_ready=0 with in_valid=1 -> exactly 5 words accepted, in_ready=0, fifo_level=4, out_data is the first word. Then set out_ready=1 -> all 5 words drain in order, fifo_level returns to 0, and out_valid=0.
4. Random in_valid and out_ready toggling (50% each) for 2000 cycles -> scoreboard shows no loss, duplication or reordering, and fifo_level never exceeds 4.
5. Assert rst_n low mid-stream with 3 words buffered -> out_valid, fifo_level, word_count and in_ready go to 0 immediately. After release, the first new word 0x0001/mode1 emerges as 0x8000.
6. Perform 65537 output handshakes -> word_count reads 0x0001, confirming the wrap at 0xFFFF->0x0000.
